// File: rtl/uart_tx_buffered.sv
// FIFO-buffered 8N1 UART transmitter on the CPU data bus.
// DATA (addr 0) pushes bytes into a FIFO; STAT/CTRL (addr 1) exposes
// ready/empty/idle/ovf and accepts clear-overflow, flush and irq enable.
// Optional feature: define UART_TX_BUFFERED_IRQ_EN to add the irq_en register
// and drive tx_irq_n from it; without it tx_irq_n is tied high.
module uart_tx_buffered #(
    parameter int unsigned CLK_FREQ   = 25_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       addr,
    input  logic       we,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       tx,
    output logic       tx_irq_n
);

    localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = PW + 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    state_e        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [BW-1:0] baud_q, baud_d;
    logic          tx_q, tx_d;

    logic wr_data;
    logic wr_ctrl;
    logic flush;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic baud_end;
    logic irq_en;

    assign wr_data    = cs & we & ~addr;
    assign wr_ctrl    = cs & we & addr;
    assign flush      = wr_ctrl & data_in[7];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    // A full FIFO drops the byte even if the serializer pops this cycle.
    assign push       = wr_data & ~fifo_full;
    assign baud_end   = (baud_q == BAUD_LAST);

    // Serializer next-state: pop/load on IDLE or end of STOP, bit timing via baud counter.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        baud_d    = baud_q;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = 3'd0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            StStop: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next frame, no idle gap.
                        pop       = 1'b1;
                        shift_d   = mem_q[rd_ptr_q];
                        bit_cnt_d = 3'd0;
                        baud_d    = '0;
                        state_d   = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Line level derived from the next state so tx is a clean flop output.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO pointer/count bookkeeping; flush wins over a same-cycle pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!push && pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Sticky overflow flag: set on a dropped write, cleared by CTRL bit3.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_data && fifo_full) begin
            ovf_d = 1'b1;
        end else if (wr_ctrl && data_in[3]) begin
            ovf_d = 1'b0;
        end
    end

    // Control/status register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            state_q   <= StIdle;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            baud_q    <= '0;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            baud_q    <= baud_d;
            tx_q      <= tx_d;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef UART_TX_BUFFERED_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_n_q, irq_n_d;

    // IRQ enable written by CTRL bit0; request asserted while the FIFO is empty.
    always_comb begin
        irq_en_d = wr_ctrl ? data_in[0] : irq_en_q;
        irq_n_d  = ~(irq_en_q & fifo_empty);
    end

    // IRQ registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_n_q  <= 1'b1;
        end else begin
            irq_en_q <= irq_en_d;
            irq_n_q  <= irq_n_d;
        end
    end

    assign irq_en   = irq_en_q;
    assign tx_irq_n = irq_n_q;
`else
    assign irq_en   = 1'b0;
    assign tx_irq_n = 1'b1;
`endif

    assign tx = tx_q;

    // Read mux: DATA reads zero, STAT reports live register state.
    always_comb begin
        data_out = 8'h00;
        if (addr) begin
            data_out = {3'b000, irq_en, ovf_q, fifo_empty & (state_q == StIdle),
                        fifo_empty, ~fifo_full};
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered. A line monitor decodes frames off
// tx into a queue; each test compares it with the bytes it expects to be sent.
module tb_uart_tx_buffered;

    localparam int unsigned CLK_FREQ   = 1000;
    localparam int unsigned BAUD_RATE  = 100;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int          DIV        = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_BUFFERED_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b0;
    logic       addr = 1'b0;
    logic       we = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       tx;
    logic       tx_irq_n;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_tx_buffered #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .addr    (addr),
        .we      (we),
        .data_in (data_in),
        .data_out(data_out),
        .tx      (tx),
        .tx_irq_n(tx_irq_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: samples each bit at its centre on the falling clock edge.
    logic [7:0] rx_q[$];
    int         rx_start[$];
    int         frame_err = 0;
    int         irq_low = 0;
    bit         mon_act = 1'b0;
    int         mon_t = 0;
    int         mon_c0 = 0;
    logic [7:0] mon_sh = 8'h00;

    always @(negedge clk) begin
        if (tx_irq_n !== 1'b1) irq_low++;
        if (rst) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act = 1'b1;
                mon_t   = 0;
                mon_c0  = cyc;
            end
        end else begin
            mon_t++;
            if (mon_t == DIV / 2 && tx !== 1'b0) frame_err++;
            if (mon_t >= DIV + DIV / 2 && mon_t < 9 * DIV && ((mon_t - DIV / 2) % DIV) == 0)
                mon_sh = {tx, mon_sh[7:1]};
            if (mon_t == 9 * DIV + DIV / 2) begin
                if (tx !== 1'b1) frame_err++;
                rx_q.push_back(mon_sh);
                rx_start.push_back(mon_c0);
                mon_act = 1'b0;
            end
        end
    end

    // Reference rules.
    function automatic logic [7:0] stat_exp(input int fifo_cnt, input bit busy,
                                            input bit ovf, input bit ien);
        stat_exp = {3'b000, ien & IRQ_BUILD, ovf, (fifo_cnt == 0) && !busy,
                    fifo_cnt == 0, fifo_cnt < FIFO_DEPTH};
    endfunction

    // Consecutive writes from idle: one goes straight to the serializer.
    function automatic int accepted_from_idle(input int k);
        accepted_from_idle = (k < FIFO_DEPTH + 1) ? k : FIFO_DEPTH + 1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(posedge clk);
        #1;
        cs = 1'b0; we = 1'b0; addr = 1'b0; data_in = 8'h00;
    endtask

    task automatic rd_stat(output logic [7:0] v);
        cs = 1'b1; addr = 1'b1;
        #1;
        v = data_out;
        cs = 1'b0; addr = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_start.delete();
    endtask

    task automatic test_reset();
        logic [7:0] s;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        rd_stat(s);
        checks++;
        if (s !== stat_exp(0, 0, 0, 0)) begin
            errors++; $display("FAIL reset_stat: got %h expected %h", s, stat_exp(0, 0, 0, 0));
        end
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++;
        if (tx_irq_n !== 1'b1) begin
            errors++; $display("FAIL reset_irq_n: got %b expected 1", tx_irq_n);
        end
    endtask

    task automatic test_single();
        logic [7:0] s;
        logic [7:0] b;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 8'h58 : 8'($urandom);
            clear_rx();
            wr(1'b0, b);
            checks++;
            if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_pre: got %b expected 1", tx); end
            rd_stat(s);
            checks++;
            if (s !== stat_exp(1, 0, 0, 0)) begin
                errors++; $display("FAIL single_stat_push: got %h expected %h", s, stat_exp(1, 0, 0, 0));
            end
            tick(1);
            checks++;
            if (tx !== 1'b0) begin errors++; $display("FAIL single_tx_start: got %b expected 0", tx); end
            rd_stat(s);
            checks++;
            if (s !== stat_exp(0, 1, 0, 0)) begin
                errors++; $display("FAIL single_stat_busy: got %h expected %h", s, stat_exp(0, 1, 0, 0));
            end
            wait_rx(1, 12 * DIV, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL single_timeout: got %0d frames expected 1", rx_q.size());
            end else if (rx_q[0] !== b) begin
                errors++; $display("FAIL single_byte: got %h expected %h", rx_q[0], b);
            end
            tick(DIV);
            rd_stat(s);
            checks++;
            if (s !== stat_exp(0, 0, 0, 0) || tx !== 1'b1) begin
                errors++; $display("FAIL single_stat_done: got %h tx %b expected %h tx 1",
                                   s, tx, stat_exp(0, 0, 0, 0));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s;
        logic [7:0] b [3];
        bit ok;
        clear_rx();
        for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) wr(1'b0, b[i]);
        tick(20 * DIV - 2);
        rd_stat(s);
        checks++;
        if (s[1] !== 1'b0) begin errors++; $display("FAIL b2b_empty_early: got %b expected 0", s[1]); end
        tick(1);
        rd_stat(s);
        checks++;
        if (s[1] !== 1'b1) begin errors++; $display("FAIL b2b_empty_last_pop: got %b expected 1", s[1]); end
        wait_rx(3, 12 * DIV, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_timeout: got %0d frames expected 3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx_q[i] !== b[i]) begin
                    errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, rx_q[i], b[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (rx_start[i] - rx_start[i-1] != 10 * DIV) begin
                    errors++; $display("FAIL b2b_spacing%0d: got %0d expected %0d",
                                       i, rx_start[i] - rx_start[i-1], 10 * DIV);
                end
            end
        end
        tick(DIV);
        checks++;
        if (frame_err != 0) begin errors++; $display("FAIL frame_format: got %0d expected 0", frame_err); end
    endtask

    // Burst of k random bytes from idle; checks STAT right after and the sent stream.
    task automatic burst_and_check(input int k, input bit clear_ovf);
        logic [7:0] s;
        logic [7:0] sent [$];
        logic [7:0] b;
        int acc;
        bit ok;
        clear_rx();
        acc = accepted_from_idle(k);
        for (int i = 0; i < k; i++) begin
            b = 8'($urandom);
            sent.push_back(b);
            wr(1'b0, b);
        end
        rd_stat(s);
        checks++;
        if (s !== stat_exp(acc - 1, 1, k > acc, 0)) begin
            errors++; $display("FAIL burst%0d_stat: got %h expected %h", k, s, stat_exp(acc - 1, 1, k > acc, 0));
        end
        if (clear_ovf) begin
            wr(1'b1, 8'h08);
            rd_stat(s);
            checks++;
            if (s[3] !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", s[3]); end
        end
        wait_rx(acc, (acc + 1) * 10 * DIV, ok);
        tick(12 * DIV);
        checks++;
        if (rx_q.size() != acc) begin
            errors++; $display("FAIL burst%0d_count: got %0d expected %0d", k, rx_q.size(), acc);
        end
        for (int i = 0; i < acc && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== sent[i]) begin
                errors++; $display("FAIL burst%0d_byte%0d: got %h expected %h", k, i, rx_q[i], sent[i]);
            end
        end
        rd_stat(s);
        checks++;
        if (s !== stat_exp(0, 0, 0, 0)) begin
            errors++; $display("FAIL burst%0d_stat_done: got %h expected %h", k, s, stat_exp(0, 0, 0, 0));
        end
    endtask

    task automatic test_fill();
        burst_and_check(FIFO_DEPTH + 1, 1'b0);
    endtask

    task automatic test_overflow();
        burst_and_check(FIFO_DEPTH + 3, 1'b1);
    endtask

    task automatic test_flush();
        logic [7:0] s;
        logic [7:0] b [4];
        bit ok;
        clear_rx();
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) wr(1'b0, b[i]);
        tick(3 * DIV);
        wr(1'b1, 8'h80);
        rd_stat(s);
        checks++;
        if (s !== stat_exp(0, 1, 0, 0)) begin
            errors++; $display("FAIL flush_stat: got %h expected %h", s, stat_exp(0, 1, 0, 0));
        end
        wait_rx(1, 12 * DIV, ok);
        tick(12 * DIV);
        checks++;
        if (rx_q.size() != 1) begin
            errors++; $display("FAIL flush_count: got %0d expected 1", rx_q.size());
        end else if (rx_q[0] !== b[0]) begin
            errors++; $display("FAIL flush_byte: got %h expected %h", rx_q[0], b[0]);
        end
        rd_stat(s);
        checks++;
        if (s !== stat_exp(0, 0, 0, 0)) begin
            errors++; $display("FAIL flush_stat_done: got %h expected %h", s, stat_exp(0, 0, 0, 0));
        end
    endtask

    // Flush lands on the same edge that pops the second byte: that byte still goes out.
    task automatic test_flush_on_pop();
        logic [7:0] b [3];
        bit ok;
        clear_rx();
        for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) wr(1'b0, b[i]);
        tick(10 * DIV - 2);
        wr(1'b1, 8'h80);
        wait_rx(2, 22 * DIV, ok);
        tick(12 * DIV);
        checks++;
        if (rx_q.size() != 2) begin
            errors++; $display("FAIL flushpop_count: got %0d expected 2", rx_q.size());
        end else if (rx_q[0] !== b[0] || rx_q[1] !== b[1]) begin
            errors++; $display("FAIL flushpop_bytes: got %h %h expected %h %h",
                               rx_q[0], rx_q[1], b[0], b[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s;
        logic [7:0] b;
        int fe0;
        bit ok;
        clear_rx();
        fe0 = frame_err;
        for (int i = 0; i < 3; i++) wr(1'b0, 8'($urandom));
        tick(4 * DIV);
        rst = 1'b1;
        tick(1);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
        rst = 1'b0;
        rd_stat(s);
        checks++;
        if (s !== stat_exp(0, 0, 0, 0)) begin
            errors++; $display("FAIL rstmid_stat: got %h expected %h", s, stat_exp(0, 0, 0, 0));
        end
        tick(12 * DIV);
        checks++;
        if (rx_q.size() != 0) begin
            errors++; $display("FAIL rstmid_abandon: got %0d frames expected 0", rx_q.size());
        end
        b = 8'($urandom);
        wr(1'b0, b);
        wait_rx(1, 12 * DIV, ok);
        checks++;
        if (!ok || rx_q[0] !== b || frame_err != fe0) begin
            errors++; $display("FAIL rstmid_clean: got %0d frames err %0d expected byte %h err %0d",
                               rx_q.size(), frame_err, b, fe0);
        end
        tick(DIV);
    endtask

    task automatic test_irq();
        logic [7:0] s;
        bit ok;
`ifdef UART_TX_BUFFERED_IRQ_EN
        clear_rx();
        wr(1'b1, 8'h01);
        checks++;
        if (tx_irq_n !== 1'b1) begin errors++; $display("FAIL irq_latency: got %b expected 1", tx_irq_n); end
        tick(1);
        checks++;
        if (tx_irq_n !== 1'b0) begin errors++; $display("FAIL irq_assert: got %b expected 0", tx_irq_n); end
        rd_stat(s);
        checks++;
        if (s !== stat_exp(0, 0, 0, 1)) begin
            errors++; $display("FAIL irq_stat: got %h expected %h", s, stat_exp(0, 0, 0, 1));
        end
        wr(1'b0, 8'($urandom));
        tick(1);
        checks++;
        if (tx_irq_n !== 1'b1) begin errors++; $display("FAIL irq_deassert: got %b expected 1", tx_irq_n); end
        tick(1);
        checks++;
        if (tx_irq_n !== 1'b0) begin errors++; $display("FAIL irq_reassert: got %b expected 0", tx_irq_n); end
        wait_rx(1, 12 * DIV, ok);
        tick(DIV);
        wr(1'b1, 8'h00);
        tick(1);
        checks++;
        if (tx_irq_n !== 1'b1) begin errors++; $display("FAIL irq_disable: got %b expected 1", tx_irq_n); end
`else
        wr(1'b1, 8'h01);
        tick(2);
        rd_stat(s);
        checks++;
        if (s !== stat_exp(0, 0, 0, 1)) begin
            errors++; $display("FAIL irq_stat_noirq: got %h expected %h", s, stat_exp(0, 0, 0, 1));
        end
        checks++;
        if (irq_low != 0 || tx_irq_n !== 1'b1) begin
            errors++; $display("FAIL irq_tied: got %0d low cycles expected 0", irq_low);
        end
        ok = 1'b1;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_overflow();
        test_flush();
        test_flush_on_pop();
        test_reset_mid();
        test_irq();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
